cipher: RTL
===========

Name: cipher

Overview:
Iterative AES encryption core, the forward-direction counterpart of decipher. It processes one 128-bit block per request at one round per clock. Round keys are pulled from the shared round-key SRAM by index (round_key_no), which has a registered 1-cycle read latency. The port shape matches decipher so both cores share the key SRAM and the controller.

Parameters:
BLK_S, 128, block width in bits (`BLK_S)
ROUND_KEY_BITS, 128, round key width (`ROUND_KEY_BITS)
NB, 4, width of rounds_total and round_key_no (`Nb)

Ports:
clk  input  1  clock; all logic on posedge
reset  input  1  synchronous, active-low reset (clears state when sampled 0 on a clk edge)
en  input  1  start pulse; sampled only in IDLE
rounds_total  input  NB  Nr for this block: 10, 12 or 14; sampled with en
plaintext  input  BLK_S  input block, FIPS-197 byte order (byte0 = [127:120], column-major); sampled with en
round_key  input  ROUND_KEY_BITS  SRAM read data = keys[round_key_no of previous cycle]
ciphertext  output  BLK_S  result register; holds until the next completion
round_key_no  output  NB  SRAM read index, registered
en_o  output  1  one-cycle done pulse; ciphertext is valid while high and afterwards

Behaviour:
- Reset (reset==0 at an edge): FSM enters IDLE; round_key_no, rnd, ciphertext, en_o and the state register all become 0. Reset has priority over everything. Reset mid-block aborts the block with no en_o.
- FSM states: IDLE, INIT, ROUND, FINAL. round_key_no is 0 throughout IDLE, so the SRAM holds keys[0].
- IDLE, en=1 and rounds_total in {10,12,14}: latch plaintext into st and rounds_total into nr; round_key_no<=1; go to INIT. If rounds_total has any other value, en is ignored and the FSM stays in IDLE.
- INIT: round_key = keys[0]. st <= st ^ round_key; rnd<=1; round_key_no<=2; go to ROUND.
- ROUND (rnd=r, round_key=keys[r]): st <= MixColumns(ShiftRows(SubBytes(st))) ^ round_key.
  - If r==nr-1: round_key_no<=0 and go to FINAL.
  - Otherwise: round_key_no<=r+2 and rnd<=r+1.
  - Invariant: round_key_no == rnd+1 throughout ROUND.
- FINAL (round_key=keys[nr]): ciphertext <= ShiftRows(SubBytes(st)) ^ round_key; en_o<=1; go to IDLE.
- en_o is 0 in every cycle except the cycle immediately after FINAL.
- Latency: with en sampled at edge E0, en_o is high in the cycle after edge E0+nr+1. That is 11, 13 and 15 cycles for Nr = 10, 12 and 14.
- Busy: en is ignored in INIT, ROUND and FINAL, with no queueing. Throughput is one block per nr+2 cycles.
- Back-to-back: en may be asserted in the cycle where en_o=1, because the FSM is already in IDLE with round_key_no=0. The new start is accepted, and ciphertext keeps the old result until the new FINAL.
- Arithmetic: all operations are GF(2^8). xtime = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 0). MixColumns uses the standard {02,03,01,01} circulant. No widths grow.
- plaintext and rounds_total are don't-care outside the cycle where en is accepted.

Decomposition:
- Shared aes.vh / aes_pkg holds:
  - `BLK_S, `ROUND_KEY_BITS, `Nb, `Nr_128=10, `Nr_192=12, `Nr_256=14
  - the forward S-box table function and xtime
  - state enum {IDLE, INIT, ROUND, FINAL}
- One combinational sub-module, enc_round(state_in, round_key, last, state_out): SubBytes, then ShiftRows, then MixColumns (bypassed when last=1), then AddRoundKey.
- cipher holds only the FSM, counters and registers.

Test Plan:
- AES-128 (FIPS-197 C.1): key SRAM loaded with the 11 expanded keys of 000102..0f; en with rounds_total=10 and plaintext 00112233445566778899aabbccddeeff -> en_o pulses once, 11 cycles later, with ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a. round_key_no sequence is 1,2,...,10,0.
- AES-192 (C.2): 13 keys of 000102..17, rounds_total=12, same plaintext -> dda97ca4864cdfe06eaf70a0ec0d7191 after 13 cycles.
- AES-256 (C.3): 15 keys of 000102..1f, rounds_total=14, same plaintext -> 8ea2b7ca516745bfeafc49904b496089 after 15 cycles.
- Back-to-back and busy: the 128-bit start is re-asserted in the en_o cycle and also pulsed mid-block -> exactly two en_o pulses, both with the 128-bit result. The mid-block pulse is ignored.
- Reset and illegal values: reset=0 driven at round 5 -> en_o never pulses, and round_key_no=0, ciphertext=0 after reset. Then en with rounds_total=11 -> the FSM stays in IDLE with no en_o.

Source files
------------

// File: rtl/cipher_pkg.sv
// Shared AES constants, state encoding and GF(2^8) helpers for the cipher core.
package cipher_pkg;

  localparam int BLK_S          = 128;
  localparam int ROUND_KEY_BITS = 128;
  localparam int NB             = 4;

  localparam logic [NB-1:0] NR_128 = 4'd10;
  localparam logic [NB-1:0] NR_192 = 4'd12;
  localparam logic [NB-1:0] NR_256 = 4'd14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    ROUND = 2'd2,
    FINAL = 2'd3
  } state_e;

  // Forward S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{8'hff - b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/cipher_enc_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module cipher_enc_round
  import cipher_pkg::*;
(
  input  logic [BLK_S-1:0]          state_in,
  input  logic [ROUND_KEY_BITS-1:0] round_key,
  input  logic                      last,
  output logic [BLK_S-1:0]          state_out
);

  logic [BLK_S-1:0] sb_s;
  logic [BLK_S-1:0] sr_s;
  logic [BLK_S-1:0] mc_s;

  // SubBytes
  always_comb begin
    sb_s = '0;
    for (int i = 0; i < 16; i++) begin
      sb_s[8*i +: 8] = sbox(state_in[8*i +: 8]);
    end
  end

  // ShiftRows: byte n sits at row n%4, column n/4, with byte 0 in the top bits
  always_comb begin
    sr_s = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_s[BLK_S-1-8*(4*c+r) -: 8] = sb_s[BLK_S-1-8*(4*((c+r)%4)+r) -: 8];
      end
    end
  end

  // MixColumns
  always_comb begin
    mc_s = '0;
    for (int c = 0; c < 4; c++) begin
      mc_s[BLK_S-1-32*c -: 32] = mix_column(sr_s[BLK_S-1-32*c -: 32]);
    end
  end

  // AddRoundKey; the final round skips MixColumns
  always_comb begin
    state_out = (last ? sr_s : mc_s) ^ round_key;
  end

endmodule

// File: rtl/cipher.sv
// Iterative AES encryption core: one round per clock, round keys fetched by index from a
// shared SRAM with one cycle of read latency.
module cipher
  import cipher_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [NB-1:0]             rounds_total,
  input  logic [BLK_S-1:0]          plaintext,
  input  logic [ROUND_KEY_BITS-1:0] round_key,
  output logic [BLK_S-1:0]          ciphertext,
  output logic [NB-1:0]             round_key_no,
  output logic                      en_o
);

  state_e           state_q;
  logic [BLK_S-1:0] st_q;
  logic [NB-1:0]    nr_q;
  logic [NB-1:0]    rnd_q;
  logic [NB-1:0]    rkn_q;
  logic [BLK_S-1:0] ct_q;
  logic             done_q;
  logic [BLK_S-1:0] round_out_s;
  logic             legal_nr_s;
  logic             last_s;

  assign legal_nr_s = (rounds_total == NR_128) || (rounds_total == NR_192) ||
                      (rounds_total == NR_256);
  assign last_s     = (state_q == FINAL);

  cipher_enc_round u_round (
    .state_in  (st_q),
    .round_key (round_key),
    .last      (last_s),
    .state_out (round_out_s)
  );

  // Sequencer: rkn_q always runs one key ahead of the round being computed
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      st_q    <= '0;
      nr_q    <= '0;
      rnd_q   <= '0;
      rkn_q   <= '0;
      ct_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (en && legal_nr_s) begin
            st_q    <= plaintext;
            nr_q    <= rounds_total;
            rkn_q   <= NB'(1);
            state_q <= INIT;
          end
        end
        INIT: begin
          st_q    <= st_q ^ round_key;
          rnd_q   <= NB'(1);
          rkn_q   <= NB'(2);
          state_q <= ROUND;
        end
        ROUND: begin
          st_q <= round_out_s;
          if (rnd_q == nr_q - NB'(1)) begin
            rkn_q   <= '0;
            state_q <= FINAL;
          end else begin
            rkn_q <= rnd_q + NB'(2);
            rnd_q <= rnd_q + NB'(1);
          end
        end
        FINAL: begin
          ct_q    <= round_out_s;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          rkn_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ciphertext   = ct_q;
  assign round_key_no = rkn_q;
  assign en_o         = done_q;

endmodule
